// File: rtl/uart_fifo.sv
`default_nettype none
// ==================================================================
// uart_fifo : parametrised UART, Wishbone-style regs, TX/RX FIFOs
// Rev 1.0
// ==================================================================

module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_pop, do_push;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // a pop frees the slot on the same edge, so a full FIFO still accepts a push
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module uart_fifo #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  tx_bit,
    input  logic                  rx_bit,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [7:0]            wb_data_in,
    output logic [7:0]            wb_data_out,
    input  logic                  wb_we,
    input  logic                  wb_stb,
    output logic                  wb_ack,
    output logic                  irq
);
    localparam logic [0:0] BUS_IDLE = 1'b0, BUS_ACK = 1'b1;
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic [0:0]           bus_q, bus_d;
    logic [7:0]           dout_q, rdata_d;
    logic [DIV_WIDTH-1:0] div_q, cnt_q;
    logic [15:0]          div_ext;
    logic [1:0]           ie_q;
    logic                 ovr_q, ferr_q, txovf_q, irq_q;
    logic                 access, wr, rd, div_wr, tick;
    logic [2:0]           a, clr;
    logic [7:0]           status;
    logic                 unused_ok;

    logic                 tx_push, tx_pop, tx_empty, tx_full, tx_busy;
    logic [DATA_BITS-1:0] tx_rdata, tsh_q;
    logic [1:0]           txs_q;
    logic [3:0]           ttc_q, tbit_q;
    logic                 tx_q, tpend_q;

    logic                 rx_push, rx_pop, rx_empty, rx_full, rx_stop_smp;
    logic [DATA_BITS-1:0] rx_rdata, rsh_q;
    logic [1:0]           rxs_q;
    logic [3:0]           rtc_q, rbit_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;

    assign unused_ok = ^{wb_addr[ADDR_WIDTH-1:3], wb_data_in};
    assign a       = wb_addr[2:0];
    assign access  = (bus_q == BUS_IDLE) && wb_stb;
    assign wr      = access && wb_we;
    assign rd      = access && !wb_we;
    assign div_wr  = wr && (a == 3'd2 || a == 3'd3);
    assign clr     = (wr && a == 3'd4) ? wb_data_in[6:4] : 3'b000;
    assign div_ext = 16'(div_q);
    assign tick    = (cnt_q == div_q);
    assign tx_busy = (txs_q != S_IDLE);
    assign status  = {tx_busy, txovf_q, ferr_q, ovr_q, rx_full, rx_empty, tx_full, tx_empty};

    assign tx_push = wr && (a == 3'd0);
    assign rx_pop  = rd && (a == 3'd1) && !rx_empty;
    assign tx_pop  = !tx_empty && ((txs_q == S_IDLE) ||
                     (txs_q == S_STOP && tick && ttc_q == 4'd15));
    assign rx_stop_smp = (rxs_q == S_STOP) && tick && (rtc_q == 4'd15);
    assign rx_push = rx_stop_smp && rx_s2_q;

    assign tx_bit      = tx_q;
    assign wb_ack      = (bus_q == BUS_ACK);
    assign wb_data_out = dout_q;
    assign irq         = irq_q;

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .reset(reset), .push_i(tx_push), .wdata_i(wb_data_in[DATA_BITS-1:0]),
        .pop_i(tx_pop), .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full));

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .reset(reset), .push_i(rx_push), .wdata_i(rsh_q),
        .pop_i(rx_pop), .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full));

    always_comb begin
        bus_d = bus_q;
        case (bus_q)
            BUS_IDLE: if (wb_stb)  bus_d = BUS_ACK;
            BUS_ACK:  if (!wb_stb) bus_d = BUS_IDLE;
            default:               bus_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = 8'h00;
        case (a)
            3'd1:    if (!rx_empty) rdata_d = 8'(rx_rdata);
            3'd2:    rdata_d = div_ext[7:0];
            3'd3:    rdata_d = div_ext[15:8];
            3'd4:    rdata_d = status;
            3'd5:    rdata_d = {6'b0, ie_q};
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_q   <= BUS_IDLE;
            dout_q  <= 8'h00;
            div_q   <= DIV_WIDTH'(DIV_RESET);
            cnt_q   <= '0;
            ie_q    <= 2'b00;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            txovf_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            bus_q <= bus_d;
            if (access) dout_q <= rdata_d;
            if (wr && a == 3'd2) div_q[7:0] <= wb_data_in;
            if (wr && a == 3'd3) div_q[DIV_WIDTH-1:8] <= wb_data_in[DIV_WIDTH-9:0];
            if (wr && a == 3'd5) ie_q <= wb_data_in[1:0];
            cnt_q   <= (div_wr || tick) ? '0 : cnt_q + 1'b1;
            // a new error event on the clearing edge wins over the clear
            ovr_q   <= (ovr_q & ~clr[0])   | (rx_push && rx_full && !rx_pop);
            ferr_q  <= (ferr_q & ~clr[1])  | (rx_stop_smp && !rx_s2_q);
            txovf_q <= (txovf_q & ~clr[2]) | (tx_push && tx_full && !tx_pop);
            irq_q   <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txs_q <= S_IDLE; tx_q <= 1'b1; tpend_q <= 1'b0;
            ttc_q <= 4'd0;   tbit_q <= 4'd0; tsh_q <= '0;
        end else begin
            case (txs_q)
                S_IDLE: if (!tx_empty) begin
                    txs_q <= S_START; tsh_q <= tx_rdata; tpend_q <= 1'b1; ttc_q <= 4'd0;
                end
                S_START: if (tick) begin
                    // the start bit is launched on the first tick after the pop
                    if (tpend_q) begin
                        tx_q <= 1'b0; tpend_q <= 1'b0; ttc_q <= 4'd0;
                    end else if (ttc_q == 4'd15) begin
                        txs_q <= S_DATA; tx_q <= tsh_q[0]; tsh_q <= tsh_q >> 1;
                        tbit_q <= 4'd0; ttc_q <= 4'd0;
                    end else ttc_q <= ttc_q + 1'b1;
                end
                S_DATA: if (tick) begin
                    if (ttc_q == 4'd15) begin
                        ttc_q <= 4'd0;
                        if (tbit_q == 4'(DATA_BITS-1)) begin
                            txs_q <= S_STOP; tx_q <= 1'b1;
                        end else begin
                            tbit_q <= tbit_q + 1'b1; tx_q <= tsh_q[0]; tsh_q <= tsh_q >> 1;
                        end
                    end else ttc_q <= ttc_q + 1'b1;
                end
                S_STOP: if (tick) begin
                    if (ttc_q == 4'd15) begin
                        ttc_q <= 4'd0;
                        if (!tx_empty) begin
                            txs_q <= S_START; tsh_q <= tx_rdata; tx_q <= 1'b0;
                        end else txs_q <= S_IDLE;
                    end else ttc_q <= ttc_q + 1'b1;
                end
                default: txs_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
            rxs_q <= S_IDLE; rtc_q <= 4'd0; rbit_q <= 4'd0; rsh_q <= '0;
        end else begin
            rx_s1_q   <= rx_bit;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rxs_q)
                S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rxs_q <= S_START; rtc_q <= 4'd0;
                end
                S_START: if (tick) begin
                    if (rtc_q == 4'd7) begin
                        rxs_q <= rx_s2_q ? S_IDLE : S_DATA;
                        rtc_q <= 4'd0; rbit_q <= 4'd0;
                    end else rtc_q <= rtc_q + 1'b1;
                end
                S_DATA: if (tick) begin
                    if (rtc_q == 4'd15) begin
                        rtc_q <= 4'd0;
                        rsh_q <= {rx_s2_q, rsh_q[DATA_BITS-1:1]};
                        if (rbit_q == 4'(DATA_BITS-1)) rxs_q <= S_STOP;
                        else rbit_q <= rbit_q + 1'b1;
                    end else rtc_q <= rtc_q + 1'b1;
                end
                S_STOP: if (tick) begin
                    if (rtc_q == 4'd15) begin
                        rtc_q <= 4'd0; rxs_q <= S_IDLE;
                    end else rtc_q <= rtc_q + 1'b1;
                end
                default: rxs_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ==================================================================
// tb_uart_fifo : self-checking bench for uart_fifo
// Rev 1.0
// ==================================================================
module tb_uart_fifo;
    localparam int DIVR = 'h123;

    logic        clk = 1'b0, reset = 1'b0;
    logic        tx_bit, rx_bit, wb_ack, irq;
    logic        wb_we = 1'b0, wb_stb = 1'b0;
    logic [11:0] wb_addr = 12'h0;
    logic [7:0]  wb_data_in = 8'h00, wb_data_out;
    logic        loop_en = 1'b0, rx_drv = 1'b1;
    int          checks = 0, errors = 0;
    logic [7:0]  exp_q[$];

    assign rx_bit = loop_en ? tx_bit : rx_drv;
    always #5 clk = ~clk;

    uart_fifo #(.ADDR_WIDTH(12), .DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16), .DIV_RESET(DIVR)) dut (
        .clk(clk), .reset(reset), .tx_bit(tx_bit), .rx_bit(rx_bit),
        .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack), .irq(irq));

    task automatic bus_access(input logic [2:0] a, input logic we, input logic [7:0] d,
                              output logic [7:0] q);
        int n;
        @(negedge clk);
        wb_addr = {9'($urandom_range(0, 511)), a};
        wb_we = we; wb_data_in = d; wb_stb = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
        q = wb_data_out;
        checks++;
        if (wb_ack !== 1'b1 || n != 1) begin
            errors++; $display("FAIL bus_ack addr=%0d ack=%b after %0d clks, want 1 after 1", a, wb_ack, n);
        end
        @(negedge clk); wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus_access(a, 1'b1, d, q);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] q);
        bus_access(a, 1'b0, 8'h00, q);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk); rx_drv = 1'b0; repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; repeat (16) @(negedge clk); end
        rx_drv = stop; repeat (16) @(negedge clk);
        rx_drv = 1'b1; repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] q;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_bit !== 1'b1 || wb_ack !== 1'b0 || irq !== 1'b0 || wb_data_out !== 8'h00) begin
            errors++; $display("FAIL reset_outputs tx=%b ack=%b irq=%b dout=%02h want 1 0 0 00",
                                tx_bit, wb_ack, irq, wb_data_out);
        end
        reset = 1'b1;
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL reset_status got %02h want 05", q); end
        rd(3'd2, q); checks++;
        if (q !== 8'h23) begin errors++; $display("FAIL reset_divlo got %02h want 23", q); end
        rd(3'd3, q); checks++;
        if (q !== 8'h01) begin errors++; $display("FAIL reset_divhi got %02h want 01", q); end
        rd(3'd5, q); checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %02h want 00", q); end
        rd(3'd1, q); checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %02h want 00", q); end
        rd(3'd6, q); checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_addr6 got %02h want 00", q); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] q, b;
        int n;
        wr(3'd2, 8'd3); wr(3'd3, 8'd0);
        b = 8'hA5;
        exp_q.push_back(8'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, b[i]});
        exp_q.push_back(8'd1);
        wr(3'd0, b);
        n = 0;
        while (tx_bit !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n < 1 || n > 4) begin errors++; $display("FAIL tx_start_latency got %0d clks want 1..4", n); end
        repeat (32) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            q = exp_q.pop_front();
            checks++;
            if (tx_bit !== q[0]) begin errors++; $display("FAIL tx_bit%0d got %b want %b", k, tx_bit, q[0]); end
            if (k < 9) begin repeat (64) @(posedge clk); #1; end
        end
        rd(3'd4, q); checks++;
        if (q !== 8'h85) begin errors++; $display("FAIL tx_busy_stop got %02h want 85", q); end
        repeat (40) @(posedge clk);
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL tx_busy_end got %02h want 05", q); end
    endtask

    task automatic test_loopback();
        logic [7:0] q, e;
        wr(3'd2, 8'd0);
        loop_en = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h00); wr(3'd0, 8'h00);
        exp_q.push_back(8'hFF); wr(3'd0, 8'hFF);
        exp_q.push_back(8'h3C); wr(3'd0, 8'h3C);
        repeat (700) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            rd(3'd1, q); checks++;
            if (q !== e) begin errors++; $display("FAIL loop_rx%0d got %02h want %02h", k, q, e); end
        end
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL loop_status got %02h want 05", q); end
        rd(3'd1, q); checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL loop_empty_read got %02h want 00", q); end
        loop_en = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] q, e, b;
        for (int k = 0; k < 17; k++) begin
            b = 8'((k * 37 + 5) & 255);
            if (k < 16) exp_q.push_back(b);
            send_rx(b, 1'b1);
        end
        rd(3'd4, q); checks++;
        if (q !== 8'h19) begin errors++; $display("FAIL ovr_status got %02h want 19", q); end
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            rd(3'd1, q); checks++;
            if (q !== e) begin errors++; $display("FAIL ovr_rx%0d got %02h want %02h", k, q, e); end
        end
        rd(3'd4, q); checks++;
        if (q !== 8'h15) begin errors++; $display("FAIL ovr_drained got %02h want 15", q); end
        wr(3'd4, 8'h10);
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL ovr_clear got %02h want 05", q); end
    endtask

    task automatic test_glitch_frame();
        logic [7:0] q;
        @(negedge clk); rx_drv = 1'b0;
        repeat (4) @(negedge clk); rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL glitch_status got %02h want 05", q); end
        send_rx(8'h55, 1'b0);
        rd(3'd4, q); checks++;
        if (q !== 8'h25) begin errors++; $display("FAIL frame_status got %02h want 25", q); end
        wr(3'd4, 8'h20);
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL frame_clear got %02h want 05", q); end
    endtask

    task automatic test_overflow_irq();
        logic [7:0] q;
        int n;
        wr(3'd5, 8'h03); checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable got %b want 1", irq); end
        for (int k = 0; k < 18; k++) wr(3'd0, 8'(k + 8'h40));
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_filled got %b want 0", irq); end
        rd(3'd4, q); checks++;
        if (q !== 8'hC6) begin errors++; $display("FAIL txovf_status got %02h want C6", q); end
        n = 0;
        while (irq !== 1'b1 && n < 4000) begin @(posedge clk); #1; n++; end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_drain got %b want 1", irq); end
        repeat (50) @(posedge clk);
        #1; checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
        wr(3'd5, 8'h01); checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable got %b want 0", irq); end
    endtask

    task automatic test_reset_midchar();
        logic [7:0] q;
        int n;
        wr(3'd5, 8'h00);
        repeat (200) @(posedge clk);
        wr(3'd0, 8'h00); wr(3'd0, 8'h11); wr(3'd0, 8'h22);
        n = 0;
        while (tx_bit !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        repeat (20) @(posedge clk);
        #2; checks++;
        if (tx_bit !== 1'b0) begin errors++; $display("FAIL midchar_low got %b want 0", tx_bit); end
        reset = 1'b0;
        #1; checks++;
        if (tx_bit !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b want 1", tx_bit); end
        @(negedge clk); reset = 1'b1;
        rd(3'd4, q); checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL midreset_status got %02h want 05", q); end
        rd(3'd2, q); checks++;
        if (q !== 8'h23) begin errors++; $display("FAIL midreset_divlo got %02h want 23", q); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_rx_overrun();
        test_glitch_frame();
        test_overflow_irq();
        test_reset_midchar();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/uart_fifo.md
# uart_fifo

Parametrised UART with a single-clock Wishbone-style register port, programmable baud divider, and separate TX and RX FIFOs. It generalises the plain UART with configurable data width, FIFO depth and divider width. It adds a real RX path (synchroniser, start-bit validation, mid-bit sampling), sticky error flags and a maskable interrupt. The block sits on the system bus next to the other peripherals and drives and receives the board serial pins.

## Interface

Parameters:
- `ADDR_WIDTH`, 12: width of `wb_addr`; only bits [2:0] are decoded.
- `DATA_BITS`, 8: bits per character, 5..8; serialised LSB first.
- `FIFO_DEPTH`, 16: entries per FIFO, power of two, ≥2.
- `DIV_WIDTH`, 16: divider register width, 9..16.
- `DIV_RESET`, 0: divider value after reset.

Ports:
- `clk`  in  1  single clock for everything, including the bus.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_bit`  out  1  serial output, idle high.
- `rx_bit`  in  1  serial input, asynchronous to `clk`.
- `wb_addr`  in  ADDR_WIDTH  register address.
- `wb_data_in`  in  8  write data.
- `wb_data_out`  out  8  read data, valid while `wb_ack`=1.
- `wb_we`  in  1  1 = write, 0 = read.
- `wb_stb`  in  1  access request.
- `wb_ack`  out  1  access acknowledge.
- `irq`  out  1  interrupt, level.

## Operation

Register map (`wb_addr[2:0]`; 6 and 7 read 0 and ignore writes):
- 0 TXDATA: write pushes `wb_data_in[DATA_BITS-1:0]`. Reads return 0.
- 1 RXDATA: read pops; data is zero-extended. Read when empty returns 0 with no pop.
- 2 DIVLO: divider bits [7:0].
- 3 DIVHI: divider bits [DIV_WIDTH-1:8]; unused bits read 0.
- 4 STATUS: bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun, bit5 frame_err, bit6 tx_overflow, bit7 tx_busy. Bits 4-6 are sticky. A write of 1 to one of these bits clears it; a write of 0 has no effect.
- 5 CTRL: bit0 ie_rx, bit1 ie_tx. Reset value 0.

Bus FSM, IDLE/ACK:
- IDLE, `wb_stb`=1: perform the access, then go to ACK with `wb_ack`=1.
- ACK: hold `wb_ack` and `wb_data_out` until `wb_stb`=0, then return to IDLE and drop `wb_ack`.
- Each strobe performs exactly one push or pop.

Baud generator:
- The counter counts 0..divider. `tick` is asserted for one clk when count==divider, so the tick period is divider+1 clks.
- A divider write restarts the counter at 0.
- Bit period is 16 ticks.

TX engine, states IDLE → START → DATA → STOP → IDLE:
- In IDLE with the FIFO non-empty, pop one entry and enter START.
- START drives 0 for 16 ticks.
- DATA sends DATA_BITS bits, 16 ticks each.
- STOP drives 1 for 16 ticks.
- From STOP, go directly to START if the FIFO is non-empty.
- `tx_busy` = state ≠ IDLE.

RX engine:
- `rx_bit` passes through a 2-flop synchroniser first.
- IDLE: a falling edge enters START with the tick counter at 0.
- START: at tick 8, sample; 1 = false start, back to IDLE; 0 = go to DATA.
- DATA: sample each bit at tick 16 after the previous sample, i.e. mid-bit.
- STOP: sample at mid-bit.
  - Stop=1 and FIFO not full: push the character.
  - Stop=1 and FIFO full: drop the character and set rx_overrun.
  - Stop=0: drop the character and set frame_err.
- Then return to IDLE.

FIFOs:
- Pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished.
- A simultaneous push and pop is legal in any state where each is individually legal. When full, pop-then-push both take effect.
- A TXDATA write while the TX FIFO is full is dropped, sets tx_overflow, and is still acked.

`irq` = (ie_rx & ~rx_empty) | (ie_tx & tx_empty), registered.

## Timing

- Reset values:
  - `tx_bit`=1, `wb_ack`=0, `wb_data_out`=0, `irq`=0.
  - Both FIFOs empty, all sticky bits 0, CTRL=0, divider=DIV_RESET.
  - Both engines IDLE, bus FSM IDLE.
- Reset asserted mid-character aborts it immediately: `tx_bit` goes to 1 asynchronously and FIFO contents are discarded.
- `wb_ack` rises on the first clk edge that samples `wb_stb`=1 in IDLE, i.e. 1-cycle latency.
- Reads return the state sampled on that edge.
- A STATUS read reflects the FIFO state before any push or pop from the same edge.
- TX: the start bit appears on `tx_bit` on the first tick after the pop; worst-case latency is divider+2 clks from the TXDATA write ack.
- RX: the pushed byte is visible in STATUS on the clk after the stop-bit sample.
- `irq` follows its sources with 1 clk latency.

## Test plan

- Reset, then read all registers → STATUS=0x05, DIV=DIV_RESET, CTRL=0, `tx_bit`=1, `irq`=0.
- Divider=3, write TXDATA=0xA5 → `tx_bit` drives 0 for 64 clks, then 1,0,1,0,0,1,0,1 at 64 clks each, then 1. `tx_busy` falls after 640 clks.
- Loopback `tx_bit`→`rx_bit`, divider=0, write 0x00, 0xFF, 0x3C → RXDATA reads return 0x00, 0xFF, 0x3C in order. Then rx_empty=1; a further read returns 0.
- Drive RX with FIFO_DEPTH+1 characters without reading → rx_full=1, rx_overrun=1, and the first FIFO_DEPTH bytes read back intact. Write STATUS=0x10 → rx_overrun=0.
- RX stimulus: a 4-tick low glitch, then a character with stop=0 → no push from the glitch, frame_err=1, rx_empty=1.
- CTRL=0x3 with the TX FIFO filled past full → tx_overflow=1, `irq` high once TX drains, `irq` low only after ie_tx is cleared. Assert reset mid-character → `tx_bit`=1 immediately.
